// File: rtl/spi_hedef_birimi_if.sv
// Word-level stream and status bundle between the SPI responder and the
// peripheral or bus bridge that feeds and drains it. Signal suffixes are named
// from the responder's point of view, so the slave modport matches the names.
interface spi_hedef_birimi_if #(
    parameter int KELIME_BIT = 8
);

    logic [KELIME_BIT-1:0] tx_veri_i;
    logic                  tx_gecerli_i;
    logic                  tx_hazir_o;
    logic [KELIME_BIT-1:0] rx_veri_o;
    logic                  rx_gecerli_o;
    logic                  rx_hazir_i;
    logic                  tx_eksik_o;
    logic                  rx_tasma_o;
    logic                  mesgul_o;

    // Responder side: consumes TX words, produces RX words and status
    modport slave (
        input  tx_veri_i,
        input  tx_gecerli_i,
        input  rx_hazir_i,
        output tx_hazir_o,
        output rx_veri_o,
        output rx_gecerli_o,
        output tx_eksik_o,
        output rx_tasma_o,
        output mesgul_o
    );

    // Peripheral side: produces TX words, consumes RX words and status
    modport master (
        output tx_veri_i,
        output tx_gecerli_i,
        output rx_hazir_i,
        input  tx_hazir_o,
        input  rx_veri_o,
        input  rx_gecerli_o,
        input  tx_eksik_o,
        input  rx_tasma_o,
        input  mesgul_o
    );

endinterface

// File: rtl/spi_hedef_birimi.sv
// SPI responder. The SPI pins are oversampled in the clk_i domain, so clk_i
// must run at least 8x the SCK rate. Words are exchanged with the local side
// through a 1-entry TX holding register and a 1-entry RX register carried on
// the interface port. The interface instance must use the same KELIME_BIT.
module spi_hedef_birimi #(
    parameter int KELIME_BIT = 8,
    parameter int SENK_ASAMA = 2
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              msb_first_i,
    input  logic              sck_i,
    input  logic              csn_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    spi_hedef_birimi_if.slave bus
);

    localparam int CNT_W = (KELIME_BIT > 2) ? $clog2(KELIME_BIT) : 1;
    localparam logic [CNT_W-1:0] SON_BIT = CNT_W'(KELIME_BIT - 1);

    typedef enum logic {
        BOSTA,
        AKTAR
    } durum_t;

    // Synchronizer chains: bit 0 takes the pin, the top bit is the usable value
    logic [SENK_ASAMA-1:0] sck_senk_q;
    logic [SENK_ASAMA-1:0] csn_senk_q;
    logic [SENK_ASAMA-1:0] mosi_senk_q;

    logic sck_s;
    logic csn_s;
    logic mosi_s;

    durum_t durum_q, durum_d;
    logic   sck_gecmis_q, sck_gecmis_d;
    logic   cpol_q, cpol_d;
    logic   cpha_q, cpha_d;
    logic   msb_q, msb_d;

    logic [CNT_W-1:0]      bit_sayac_q, bit_sayac_d;
    logic [KELIME_BIT-1:0] rx_kaydirma_q, rx_kaydirma_d;
    logic [KELIME_BIT-1:0] tx_kaydirma_q, tx_kaydirma_d;
    logic [KELIME_BIT-1:0] tx_tutucu_q, tx_tutucu_d;
    logic                  tx_dolu_q, tx_dolu_d;
    logic [KELIME_BIT-1:0] rx_veri_q, rx_veri_d;
    logic                  rx_gecerli_q, rx_gecerli_d;
    logic                  tx_eksik_q, tx_eksik_d;
    logic                  rx_tasma_q, rx_tasma_d;
    logic                  miso_q, miso_d;
    logic                  miso_oe_q, miso_oe_d;

    logic                  on_kenar;
    logic                  arka_kenar;
    logic                  ornek_kenar;
    logic                  kaydir_kenar;
    logic                  yukle;
    logic                  kelime_tamam;
    logic                  msb_etkin;
    logic [KELIME_BIT-1:0] rx_yeni;
    logic [KELIME_BIT-1:0] tx_kaymis;

    assign sck_s  = sck_senk_q[SENK_ASAMA-1];
    assign csn_s  = csn_senk_q[SENK_ASAMA-1];
    assign mosi_s = mosi_senk_q[SENK_ASAMA-1];

    // Bring the asynchronous SPI pins into the clk_i domain; CS idles deasserted
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sck_senk_q  <= '0;
            csn_senk_q  <= '1;
            mosi_senk_q <= '0;
        end else begin
            sck_senk_q  <= {sck_senk_q[SENK_ASAMA-2:0], sck_i};
            csn_senk_q  <= {csn_senk_q[SENK_ASAMA-2:0], csn_i};
            mosi_senk_q <= {mosi_senk_q[SENK_ASAMA-2:0], mosi_i};
        end
    end

    // State and datapath registers; reset mid-transfer drops everything in flight
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            durum_q       <= BOSTA;
            sck_gecmis_q  <= 1'b0;
            cpol_q        <= 1'b0;
            cpha_q        <= 1'b0;
            msb_q         <= 1'b0;
            bit_sayac_q   <= '0;
            rx_kaydirma_q <= '0;
            tx_kaydirma_q <= '0;
            tx_tutucu_q   <= '0;
            tx_dolu_q     <= 1'b0;
            rx_veri_q     <= '0;
            rx_gecerli_q  <= 1'b0;
            tx_eksik_q    <= 1'b0;
            rx_tasma_q    <= 1'b0;
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
        end else begin
            durum_q       <= durum_d;
            sck_gecmis_q  <= sck_gecmis_d;
            cpol_q        <= cpol_d;
            cpha_q        <= cpha_d;
            msb_q         <= msb_d;
            bit_sayac_q   <= bit_sayac_d;
            rx_kaydirma_q <= rx_kaydirma_d;
            tx_kaydirma_q <= tx_kaydirma_d;
            tx_tutucu_q   <= tx_tutucu_d;
            tx_dolu_q     <= tx_dolu_d;
            rx_veri_q     <= rx_veri_d;
            rx_gecerli_q  <= rx_gecerli_d;
            tx_eksik_q    <= tx_eksik_d;
            rx_tasma_q    <= rx_tasma_d;
            miso_q        <= miso_d;
            miso_oe_q     <= miso_oe_d;
        end
    end

    // Edge classification against the SCK idle level latched at CS assertion
    always_comb begin
        on_kenar     = (sck_gecmis_q == cpol_q) && (sck_s != cpol_q);
        arka_kenar   = (sck_gecmis_q != cpol_q) && (sck_s == cpol_q);
        ornek_kenar  = cpha_q ? arka_kenar : on_kenar;
        kaydir_kenar = cpha_q ? on_kenar : arka_kenar;
        rx_yeni      = msb_q ? {rx_kaydirma_q[KELIME_BIT-2:0], mosi_s}
                             : {mosi_s, rx_kaydirma_q[KELIME_BIT-1:1]};
        tx_kaymis    = msb_q ? {tx_kaydirma_q[KELIME_BIT-2:0], 1'b0}
                             : {1'b0, tx_kaydirma_q[KELIME_BIT-1:1]};
    end

    // Transfer FSM plus TX holding / RX delivery; the sample path runs even in
    // the cycle CS is seen rising so a just-completed word is still delivered
    always_comb begin
        durum_d       = durum_q;
        sck_gecmis_d  = sck_s;
        cpol_d        = cpol_q;
        cpha_d        = cpha_q;
        msb_d         = msb_q;
        bit_sayac_d   = bit_sayac_q;
        rx_kaydirma_d = rx_kaydirma_q;
        tx_kaydirma_d = tx_kaydirma_q;
        tx_tutucu_d   = tx_tutucu_q;
        tx_dolu_d     = tx_dolu_q;
        rx_veri_d     = rx_veri_q;
        rx_gecerli_d  = rx_gecerli_q;
        tx_eksik_d    = 1'b0;
        rx_tasma_d    = 1'b0;
        miso_oe_d     = miso_oe_q;
        miso_d        = 1'b0;
        yukle         = 1'b0;
        kelime_tamam  = 1'b0;
        msb_etkin     = msb_q;

        case (durum_q)
            BOSTA: begin
                miso_oe_d = 1'b0;
                if (!csn_s) begin
                    durum_d       = AKTAR;
                    cpol_d        = cpol_i;
                    cpha_d        = cpha_i;
                    msb_d         = msb_first_i;
                    msb_etkin     = msb_first_i;
                    sck_gecmis_d  = cpol_i;
                    bit_sayac_d   = '0;
                    rx_kaydirma_d = '0;
                    miso_oe_d     = 1'b1;
                    yukle         = 1'b1;
                end
            end
            AKTAR: begin
                if (ornek_kenar) begin
                    rx_kaydirma_d = rx_yeni;
                    if (bit_sayac_q == SON_BIT) begin
                        kelime_tamam = 1'b1;
                        bit_sayac_d  = '0;
                        yukle        = 1'b1;
                    end else begin
                        bit_sayac_d = bit_sayac_q + CNT_W'(1);
                    end
                end else if (kaydir_kenar && (bit_sayac_q != '0)) begin
                    tx_kaydirma_d = tx_kaymis;
                end
                if (csn_s) begin
                    durum_d   = BOSTA;
                    miso_oe_d = 1'b0;
                end
            end
            default: begin
                durum_d   = BOSTA;
                miso_oe_d = 1'b0;
            end
        endcase

        if (yukle) begin
            if (tx_dolu_q) begin
                tx_kaydirma_d = tx_tutucu_q;
                tx_dolu_d     = 1'b0;
            end else begin
                tx_kaydirma_d = '0;
                tx_eksik_d    = 1'b1;
            end
        end

        if (bus.tx_gecerli_i && !tx_dolu_q) begin
            tx_tutucu_d = bus.tx_veri_i;
            tx_dolu_d   = 1'b1;
        end

        if (rx_gecerli_q && bus.rx_hazir_i) begin
            rx_gecerli_d = 1'b0;
        end

        if (kelime_tamam) begin
            if (!rx_gecerli_q || bus.rx_hazir_i) begin
                rx_veri_d    = rx_yeni;
                rx_gecerli_d = 1'b1;
            end else begin
                rx_tasma_d = 1'b1;
            end
        end

        if (durum_d == AKTAR) begin
            miso_d = msb_etkin ? tx_kaydirma_d[KELIME_BIT-1] : tx_kaydirma_d[0];
        end
    end

    assign miso_o           = miso_q;
    assign miso_oe_o        = miso_oe_q;
    assign bus.tx_hazir_o   = ~tx_dolu_q;
    assign bus.rx_veri_o    = rx_veri_q;
    assign bus.rx_gecerli_o = rx_gecerli_q;
    assign bus.tx_eksik_o   = tx_eksik_q;
    assign bus.rx_tasma_o   = rx_tasma_q;
    assign bus.mesgul_o     = ~csn_s;

endmodule

// File: tb/tb_spi_hedef_birimi.sv
// Directed bench for the SPI responder: a behavioural SPI controller drives the
// pins with SCK half-periods of 8 clk_i cycles, and a monitor logs every word
// accepted on the RX stream plus every underrun and overrun pulse.
module tb_spi_hedef_birimi;

   localparam int HALF = 80;

   logic clock = 1'b0;
   logic resetN;
   logic cpol;
   logic cpha;
   logic msbFirst;
   logic sck;
   logic csn;
   logic mosi;
   logic miso;
   logic misoOe;

   int checks = 0;
   int errors = 0;
   int eksikCount = 0;
   int tasmaCount = 0;
   logic [7:0] rxLog[$];

   spi_hedef_birimi_if #(.KELIME_BIT(8)) bus ();

   spi_hedef_birimi #(
      .KELIME_BIT(8),
      .SENK_ASAMA(2)
   ) dut (
      .clk_i      (clock),
      .rstn_i     (resetN),
      .cpol_i     (cpol),
      .cpha_i     (cpha),
      .msb_first_i(msbFirst),
      .sck_i      (sck),
      .csn_i      (csn),
      .mosi_i     (mosi),
      .miso_o     (miso),
      .miso_oe_o  (misoOe),
      .bus        (bus.slave)
   );

   // 100 MHz system clock, negedges fall on multiples of 10 ns
   always #5 clock = ~clock;

   // Record RX handshakes and status pulses away from the active edge
   always @(negedge clock) begin
      if (resetN) begin
         if (bus.rx_gecerli_o && bus.rx_hazir_i) rxLog.push_back(bus.rx_veri_o);
         if (bus.tx_eksik_o) eksikCount++;
         if (bus.rx_tasma_o) tasmaCount++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Push one word into the TX holding register once it reports empty
   task automatic txWrite(input logic [7:0] data);
      int waited;
      waited = 0;
      @(negedge clock);
      while (!bus.tx_hazir_o && waited < 200) begin
         @(negedge clock);
         waited++;
      end
      checkOutput("tx_hazir_wait", 32'(bus.tx_hazir_o), 32'd1);
      bus.tx_veri_i = data;
      bus.tx_gecerli_i = 1'b1;
      @(negedge clock);
      bus.tx_gecerli_i = 1'b0;
   endtask

   task automatic csAssert();
      sck = cpol;
      csn = 1'b0;
      #HALF;
   endtask

   task automatic csRelease();
      #HALF;
      csn = 1'b1;
      #(2 * HALF);
   endtask

   // Clock nBits bits of mosiWord out as the controller, capturing miso at the
   // controller's sample edge in the same bit order
   task automatic applyStimulus(input logic [7:0] mosiWord, input int nBits, output logic [7:0] misoWord);
      int idx;
      misoWord = 8'h00;
      for (int i = 0; i < nBits; i++) begin
         idx = msbFirst ? (7 - i) : i;
         if (!cpha) begin
            mosi = mosiWord[idx];
            #HALF;
            sck = ~cpol;
            misoWord[idx] = miso;
            #HALF;
            sck = cpol;
         end else begin
            sck = ~cpol;
            mosi = mosiWord[idx];
            #HALF;
            sck = cpol;
            misoWord[idx] = miso;
            #HALF;
         end
      end
   endtask

   // Directed sequence covering reset, modes 0/1/3, back-to-back words,
   // underrun, overrun, aborted transfer, LSB-first and async reset
   initial begin
      logic [7:0] miWord;
      int rxBase;
      int eksikBase;
      int tasmaBase;

      resetN = 1'b0;
      cpol = 1'b0;
      cpha = 1'b0;
      msbFirst = 1'b1;
      sck = 1'b0;
      csn = 1'b1;
      mosi = 1'b0;
      miWord = 8'h00;
      bus.tx_veri_i = 8'h00;
      bus.tx_gecerli_i = 1'b0;
      bus.rx_hazir_i = 1'b1;

      #23;
      checkOutput("reset_tx_hazir", 32'(bus.tx_hazir_o), 32'd1);
      checkOutput("reset_rx_gecerli", 32'(bus.rx_gecerli_o), 32'd0);
      checkOutput("reset_rx_veri", 32'(bus.rx_veri_o), 32'h00);
      checkOutput("reset_miso", 32'(miso), 32'd0);
      checkOutput("reset_miso_oe", 32'(misoOe), 32'd0);
      checkOutput("reset_mesgul", 32'(bus.mesgul_o), 32'd0);
      checkOutput("reset_tx_eksik", 32'(bus.tx_eksik_o), 32'd0);
      checkOutput("reset_rx_tasma", 32'(bus.rx_tasma_o), 32'd0);
      @(negedge clock);
      resetN = 1'b1;
      repeat (3) @(negedge clock);

      $display("[TB] mode 0 MSB-first single word");
      txWrite(8'hA5);
      rxBase = rxLog.size();
      csAssert();
      checkOutput("t1_mesgul", 32'(bus.mesgul_o), 32'd1);
      checkOutput("t1_miso_oe", 32'(misoOe), 32'd1);
      applyStimulus(8'h3C, 8, miWord);
      csRelease();
      checkOutput("t1_miso_word", 32'(miWord), 32'hA5);
      checkOutput("t1_rx_count", 32'(rxLog.size() - rxBase), 32'd1);
      checkOutput("t1_rx_word", 32'(rxLog[rxLog.size() - 1]), 32'h3C);
      checkOutput("t1_miso_oe_off", 32'(misoOe), 32'd0);
      checkOutput("t1_mesgul_off", 32'(bus.mesgul_o), 32'd0);

      $display("[TB] mode 3 two words under one CS");
      cpol = 1'b1;
      cpha = 1'b1;
      sck = 1'b1;
      #HALF;
      txWrite(8'h12);
      eksikBase = eksikCount;
      rxBase = rxLog.size();
      csAssert();
      txWrite(8'h34);
      applyStimulus(8'hF0, 8, miWord);
      checkOutput("t2_miso_word0", 32'(miWord), 32'h12);
      txWrite(8'h00);
      applyStimulus(8'h0F, 8, miWord);
      checkOutput("t2_miso_word1", 32'(miWord), 32'h34);
      csRelease();
      checkOutput("t2_rx_count", 32'(rxLog.size() - rxBase), 32'd2);
      checkOutput("t2_rx_word0", 32'(rxLog[rxBase]), 32'hF0);
      checkOutput("t2_rx_word1", 32'(rxLog[rxBase + 1]), 32'h0F);
      checkOutput("t2_no_eksik", 32'(eksikCount - eksikBase), 32'd0);

      $display("[TB] mode 1 with empty TX register");
      cpol = 1'b0;
      cpha = 1'b1;
      sck = 1'b0;
      #HALF;
      eksikBase = eksikCount;
      rxBase = rxLog.size();
      csAssert();
      checkOutput("t3_eksik_at_cs", 32'(eksikCount - eksikBase), 32'd1);
      applyStimulus(8'h77, 8, miWord);
      csRelease();
      checkOutput("t3_miso_zero", 32'(miWord), 32'h00);
      checkOutput("t3_rx_word", 32'(rxLog[rxLog.size() - 1]), 32'h77);
      checkOutput("t3_rx_count", 32'(rxLog.size() - rxBase), 32'd1);
      checkOutput("t3_eksik_reload", 32'(eksikCount - eksikBase), 32'd2);

      $display("[TB] mode 0 overrun while consumer stalls");
      cpha = 1'b0;
      #HALF;
      bus.rx_hazir_i = 1'b0;
      tasmaBase = tasmaCount;
      rxBase = rxLog.size();
      csAssert();
      applyStimulus(8'hAA, 8, miWord);
      applyStimulus(8'h55, 8, miWord);
      csRelease();
      checkOutput("t4_rx_veri_held", 32'(bus.rx_veri_o), 32'hAA);
      checkOutput("t4_rx_gecerli_held", 32'(bus.rx_gecerli_o), 32'd1);
      checkOutput("t4_tasma_pulse", 32'(tasmaCount - tasmaBase), 32'd1);
      checkOutput("t4_no_pop_yet", 32'(rxLog.size() - rxBase), 32'd0);
      @(posedge clock);
      #2;
      bus.rx_hazir_i = 1'b1;
      @(negedge clock);
      @(negedge clock);
      checkOutput("t4_pop_count", 32'(rxLog.size() - rxBase), 32'd1);
      checkOutput("t4_pop_word", 32'(rxLog[rxLog.size() - 1]), 32'hAA);
      checkOutput("t4_rx_gecerli_clear", 32'(bus.rx_gecerli_o), 32'd0);

      $display("[TB] aborted partial word then LSB-first word");
      msbFirst = 1'b1;
      rxBase = rxLog.size();
      csAssert();
      checkOutput("t5_oe_on", 32'(misoOe), 32'd1);
      applyStimulus(8'hFF, 5, miWord);
      csRelease();
      checkOutput("t5_oe_off", 32'(misoOe), 32'd0);
      checkOutput("t5_miso_off", 32'(miso), 32'd0);
      checkOutput("t5_partial_dropped", 32'(rxLog.size() - rxBase), 32'd0);
      msbFirst = 1'b0;
      txWrite(8'h3C);
      csAssert();
      checkOutput("t5_oe_on_lsb", 32'(misoOe), 32'd1);
      applyStimulus(8'h5A, 8, miWord);
      csRelease();
      checkOutput("t5_miso_word_lsb", 32'(miWord), 32'h3C);
      checkOutput("t5_rx_count", 32'(rxLog.size() - rxBase), 32'd1);
      checkOutput("t5_rx_word_lsb", 32'(rxLog[rxLog.size() - 1]), 32'h5A);
      checkOutput("t5_rx_veri", 32'(bus.rx_veri_o), 32'h5A);

      $display("[TB] asynchronous reset mid-word");
      msbFirst = 1'b1;
      txWrite(8'hE7);
      csAssert();
      txWrite(8'h81);
      checkOutput("t6_tx_full", 32'(bus.tx_hazir_o), 32'd0);
      applyStimulus(8'hFF, 3, miWord);
      #2;
      resetN = 1'b0;
      #1;
      checkOutput("t6_rst_tx_hazir", 32'(bus.tx_hazir_o), 32'd1);
      checkOutput("t6_rst_rx_gecerli", 32'(bus.rx_gecerli_o), 32'd0);
      checkOutput("t6_rst_rx_veri", 32'(bus.rx_veri_o), 32'h00);
      checkOutput("t6_rst_miso", 32'(miso), 32'd0);
      checkOutput("t6_rst_miso_oe", 32'(misoOe), 32'd0);
      checkOutput("t6_rst_mesgul", 32'(bus.mesgul_o), 32'd0);
      sck = 1'b0;
      csn = 1'b1;
      mosi = 1'b0;
      #40;
      @(negedge clock);
      resetN = 1'b1;
      repeat (4) @(negedge clock);
      txWrite(8'h96);
      rxBase = rxLog.size();
      csAssert();
      applyStimulus(8'hC3, 8, miWord);
      csRelease();
      checkOutput("t6_clean_miso", 32'(miWord), 32'h96);
      checkOutput("t6_clean_rx_count", 32'(rxLog.size() - rxBase), 32'd1);
      checkOutput("t6_clean_rx_word", 32'(rxLog[rxLog.size() - 1]), 32'hC3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard time limit so a stuck handshake can never hang the run
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
